// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline write-enable/flush/bubble sequencing for the 5-stage core.
// Optional performance counters (stall_cnt, flush_cnt) enabled by PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CW     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  input  logic       id_branch_taken,
  input  logic       id_jump,
  input  logic       ex_mc_start,
  input  logic       mem_wait,
  output logic       c_PCWrite,
  output logic       c_IFIDWrite,
  output logic       c_IDEXWrite,
  output logic       c_EXMEMWrite,
  output logic       c_if_flush,
  output logic       c_idex_bubble,
  output logic       c_exmem_bubble,
  output logic       c_mc_last,
  output logic [1:0] state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  typedef enum logic [1:0] {RUN = 2'd0, MC_WAIT = 2'd1} state_t;
  state_t st, st_nx;
  logic [CW-1:0] mc_cnt, mc_cnt_nx;
  logic lu, mc, redir, run, cnt_one;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st     <= RUN;
      mc_cnt <= '0;
    end else begin
      st     <= st_nx;
      mc_cnt <= mc_cnt_nx;
    end
  always_comb begin
    st_nx     = st;
    mc_cnt_nx = mc_cnt;
    if (st == RUN) begin
      if (ex_mc_start && !mem_wait && MC_LAT >= 2) begin
        st_nx     = MC_WAIT;
        mc_cnt_nx = CW'(MC_LAT - 1);
      end
    end else if (!cnt_one) begin
      mc_cnt_nx = mc_cnt - CW'(1);
    end else if (!mem_wait) begin
      st_nx     = RUN;
      mc_cnt_nx = '0;
    end
  end
  assign lu      = idex_memread && idex_rt != 5'd0 &&
                   (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
  assign cnt_one = mc_cnt == CW'(1);
  assign mc      = st == MC_WAIT || ex_mc_start;
  assign redir   = id_branch_taken || id_jump;
  // run gates everything: reset forces all controls low, mem_wait freezes all
  assign run            = rst_n && !mem_wait;
  assign c_PCWrite      = run && !mc && !lu;
  assign c_IFIDWrite    = run && !mc && !lu;
  assign c_IDEXWrite    = run && !mc;
  assign c_EXMEMWrite   = run;
  assign c_exmem_bubble = run && mc;
  assign c_idex_bubble  = run && !mc && lu;
  assign c_if_flush     = run && !mc && !lu && redir;
  assign c_mc_last      = run && ((st == MC_WAIT && cnt_one) ||
                                  (st == RUN && ex_mc_start && MC_LAT == 1));
  assign state          = st;
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, !c_PCWrite};
      flush_cnt <= flush_cnt + {31'd0, c_if_flush};
    end
`endif
endmodule
